// File: rtl/tri_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// tri_bus_arbiter_pkg
// Shared definitions for the tri-state bus arbiter: FSM state encoding and the
// default values of the arbiter parameters.
// -----------------------------------------------------------------------------
package tri_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_TURN = 2'd2
    } arb_state_e;

    localparam int DEF_N_REQ    = 4;
    localparam int DEF_WIDTH    = 8;
    localparam int DEF_MAX_HOLD = 16;

endpackage : tri_bus_arbiter_pkg

// File: rtl/tri_bus_arbiter_bus_drv.sv
// -----------------------------------------------------------------------------
// bus_drv
// One requester's tri-state driver onto the shared bus.
// Ports:
//   en   - drive enable; when low the driver releases the bus (all Z)
//   din  - data driven onto the bus while enabled
//   bus  - shared tri-state bus
// -----------------------------------------------------------------------------
module bus_drv #(
    parameter int WIDTH = 8
) (
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    inout  wire  [WIDTH-1:0] bus
);

    assign bus = en ? din : {WIDTH{1'bz}};

endmodule : bus_drv

// File: rtl/tri_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tri_bus_arbiter
// Round-robin arbiter for a shared tri-state bus. One owner at a time may drive
// the bus, for at most MAX_HOLD consecutive cycles; every ownership ends with a
// one-cycle turnaround (no driver enabled) followed by an IDLE cycle.
// Ports:
//   clk     - clock, rising edge
//   rst     - asynchronous active-high reset
//   req     - per-requester bus request (level)
//   sig_in  - per-requester drive data, slice i at [i*WIDTH +: WIDTH]
//   grant   - registered one-hot-or-zero ownership
//   enable  - registered per-requester drive enable (always equals grant)
//   sig_out - shared tri-state bus
//   busy    - high while in OWN or TURN
// -----------------------------------------------------------------------------
module tri_bus_arbiter
    import tri_bus_arbiter_pkg::*;
#(
    parameter int N_REQ    = DEF_N_REQ,
    parameter int WIDTH    = DEF_WIDTH,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] sig_in,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       enable,
    inout  wire  [WIDTH-1:0]       sig_out,
    output logic                   busy
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_REQ - 1);
    localparam logic [7:0]       HOLD_LAST = 8'(MAX_HOLD - 1);

    arb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [IDX_W-1:0]  last_owner_q, last_owner_d;
    logic [7:0]        hold_cnt_q, hold_cnt_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [N_REQ-1:0]  enable_q, enable_d;

    logic              win_found;
    logic [IDX_W-1:0]  win_idx;
    logic [IDX_W-1:0]  cand_idx;
    int                cand;

    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Round-robin search: start one past the previous owner and wrap, so the
    // previous owner is considered last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand     = (int'(last_owner_q) + 1 + k) % N_REQ;
            cand_idx = IDX_W'(cand);
            if (!win_found && req[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        hold_cnt_d   = hold_cnt_q;
        grant_d      = grant_q;
        enable_d     = enable_q;

        unique case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d    = ST_OWN;
                    owner_d    = win_idx;
                    hold_cnt_d = '0;
                    grant_d    = onehot(win_idx);
                    enable_d   = onehot(win_idx);
                end
            end
            ST_OWN: begin
                if (!req[owner_q] || (hold_cnt_q == HOLD_LAST)) begin
                    state_d      = ST_TURN;
                    last_owner_d = owner_q;
                    hold_cnt_d   = '0;
                    grant_d      = '0;
                    enable_d     = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            ST_TURN: begin
                // Turnaround: no driver enabled, requests ignored.
                state_d = ST_IDLE;
            end
            default: begin
                state_d  = ST_IDLE;
                grant_d  = '0;
                enable_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= '0;
            last_owner_q <= LAST_IDX;
            hold_cnt_q   <= '0;
            grant_q      <= '0;
            enable_q     <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            hold_cnt_q   <= hold_cnt_d;
            grant_q      <= grant_d;
            enable_q     <= enable_d;
        end
    end

    assign grant  = grant_q;
    assign enable = enable_q;
    assign busy   = (state_q != ST_IDLE);

    for (genvar g = 0; g < N_REQ; g++) begin : g_drv
        bus_drv #(
            .WIDTH (WIDTH)
        ) u_bus_drv (
            .en  (enable_q[g]),
            .din (sig_in[g*WIDTH +: WIDTH]),
            .bus (sig_out)
        );
    end

endmodule : tri_bus_arbiter

// File: tb/tb_tri_bus_arbiter.sv
module tb_tri_bus_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_a, rst_b;
    logic [N-1:0] req_a, req_b;
    logic [N*W-1:0] sig_in_a, sig_in_b;
    logic [N-1:0] grant_a, enable_a, grant_b, enable_b;
    logic         busy_a, busy_b;
    wire  [W-1:0] sig_out_a;
    wire  [W-1:0] sig_out_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tri_bus_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_HOLD(16)) dut_a (
        .clk(clk), .rst(rst_a), .req(req_a), .sig_in(sig_in_a),
        .grant(grant_a), .enable(enable_a), .sig_out(sig_out_a), .busy(busy_a)
    );

    tri_bus_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_HOLD(4)) dut_b (
        .clk(clk), .rst(rst_b), .req(req_b), .sig_in(sig_in_b),
        .grant(grant_b), .enable(enable_b), .sig_out(sig_out_b), .busy(busy_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // A released bus reads all Z; a two-state simulator shows it as 0.
    // All data patterns used here are nonzero, so 0 cannot be driven data.
    task automatic check_released(input string tag, input logic [W-1:0] obs);
        checks++;
        assert ((obs === {W{1'bz}}) || (obs === {W{1'b0}})) else begin
            errors++;
            $error("FAIL %s: observed %0h expected released bus", tag, obs);
        end
    endtask

    function automatic logic [W-1:0] slice_a(input int i);
        return sig_in_a[i*W +: W];
    endfunction

    task automatic check_own_a(input string tag, input int idx);
        logic [N-1:0] oh;
        oh = '0;
        oh[idx] = 1'b1;
        check({tag, "_grant"},  64'(grant_a),  64'(oh));
        check({tag, "_enable"}, 64'(enable_a), 64'(oh));
        check({tag, "_busy"},   64'(busy_a),   64'd1);
        check({tag, "_bus"},    64'(sig_out_a), 64'(slice_a(idx)));
    endtask

    task automatic check_free_a(input string tag, input logic exp_busy);
        check({tag, "_grant"},  64'(grant_a),  64'd0);
        check({tag, "_enable"}, 64'(enable_a), 64'd0);
        check({tag, "_busy"},   64'(busy_a),   64'(exp_busy));
        check_released({tag, "_bus"}, sig_out_a);
    endtask

    initial begin
        int owners [5];
        int idx;
        owners = '{0, 1, 2, 3, 0};

        rst_a    = 1'b1;
        rst_b    = 1'b1;
        req_a    = '0;
        req_b    = '0;
        sig_in_a = 32'hD3C2B1A0;
        sig_in_b = 32'h44332211;
        #1;

        // Reset state
        check_free_a("reset", 1'b0);
        check("reset_b_grant", 64'(grant_b), 64'd0);
        step();
        step();
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Idle with no request stays idle
        step();
        check_free_a("idle_noreq", 1'b0);

        // Single requester 2
        req_a = 4'b0100;
        step();
        check_own_a("single_own0", 2);
        step();
        step();
        check_own_a("single_own2", 2);
        req_a = 4'b0000;
        step();
        check_free_a("single_turn", 1'b1);
        step();
        check_free_a("single_idle", 1'b0);

        // All requesters from reset: owners 0,1,2,3,0, 16 cycles each, 2-cycle gap
        rst_a = 1'b1;
        #2;
        rst_a = 1'b0;
        req_a = 4'b1111;
        for (int o = 0; o < 5; o++) begin
            step();
            for (int h = 0; h < 16; h++) begin
                if (h > 0) step();
                check_own_a($sformatf("rr_o%0d_h%0d", o, h), owners[o]);
            end
            step();
            check_free_a($sformatf("rr_o%0d_turn", o), 1'b1);
            step();
            check_free_a($sformatf("rr_o%0d_idle", o), 1'b0);
        end

        // Reset mid-OWN while requester 3 owns the bus
        rst_a = 1'b1;
        #2;
        rst_a = 1'b0;
        req_a = 4'b1000;
        step();
        check_own_a("rst_own3", 3);
        #2;
        rst_a = 1'b1;
        #1;
        check_free_a("rst_async", 1'b0);
        req_a = 4'b0110;
        step();
        check_free_a("rst_held", 1'b0);
        rst_a = 1'b0;
        step();
        check_own_a("rst_first", 1);
        req_a = 4'b0000;
        step();
        step();

        // Hold limit on the MAX_HOLD=4 instance
        req_b = 4'b0001;
        step();
        for (int h = 0; h < 4; h++) begin
            if (h > 0) step();
            check($sformatf("hold_grant_h%0d", h), 64'(grant_b), 64'd1);
            check($sformatf("hold_bus_h%0d", h), 64'(sig_out_b), 64'h11);
        end
        step();
        check("hold_turn_grant", 64'(grant_b), 64'd0);
        check("hold_turn_busy",  64'(busy_b),  64'd1);
        check_released("hold_turn_bus", sig_out_b);
        step();
        check("hold_idle_grant", 64'(grant_b), 64'd0);
        check("hold_idle_busy",  64'(busy_b),  64'd0);
        step();
        check("hold_regrant", 64'(grant_b), 64'd1);
        check("hold_regrant_en", 64'(enable_b), 64'd1);
        req_b = 4'b0000;

        // Random contention on the default instance
        for (int c = 0; c < 10000; c++) begin
            req_a = 4'($urandom_range(0, 15));
            step();
            check("rand_onehot", 64'($countones(enable_a) <= 1), 64'd1);
            check("rand_en_eq_grant", 64'(enable_a), 64'(grant_a));
            if (enable_a != '0) begin
                idx = 0;
                for (int i = 0; i < N; i++) if (enable_a[i]) idx = i;
                check("rand_bus", 64'(sig_out_a), 64'(slice_a(idx)));
            end else begin
                check_released("rand_bus_free", sig_out_a);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_tri_bus_arbiter

// File: doc/tri_bus_arbiter.md
TRI_BUS_ARBITER -- requirements
Module: tri_bus_arbiter

Interface
REQ-001 Parameter: N_REQ, default 4, number of requesters sharing the bus.
REQ-002 Parameter: WIDTH, default 8, shared bus width in bits.
REQ-003 Parameter: MAX_HOLD, default 16, maximum consecutive cycles one owner may hold the bus (range 1..255).
REQ-004 Port: clk  input  1  single clock; every state element updates on its rising edge.
REQ-005 Port: rst  input  1  asynchronous, active-high reset.
REQ-006 Port: req  input  N_REQ  per-requester bus request; the requester holds it high while it wants the bus.
REQ-007 Port: sig_in  input  N_REQ*WIDTH  per-requester drive data; slice i is bits [i*WIDTH +: WIDTH].
REQ-008 Port: grant  output  N_REQ  registered, one-hot-or-zero ownership indication.
REQ-009 Port: enable  output  N_REQ  registered per-requester tri-state drive enable.
REQ-010 Port: sig_out  inout  WIDTH  shared tri-state bus.
REQ-011 Port: busy  output  1  high in OWN and TURN states.

Function
REQ-012 The block shall implement three states: IDLE, OWN and TURN.
REQ-013 IDLE, no req bit set: remain in IDLE with grant=0 and enable=0.
REQ-014 IDLE, any req bit set: on the next edge, go to OWN and set grant and enable to the one-hot winner; grant latency is 1 cycle.
REQ-015 Winner selection: round-robin; search starts at index (last_owner+1) mod N_REQ and wraps; last_owner resets to N_REQ-1, so index 0 has first priority.
REQ-016 OWN, owner's req high and hold_cnt < MAX_HOLD-1: remain in OWN and increment hold_cnt; hold_cnt is 0 on the first OWN cycle.
REQ-017 OWN, owner's req low or hold_cnt == MAX_HOLD-1: on the next edge, go to TURN, clear grant and enable, and load last_owner with the owner index.
REQ-018 TURN lasts exactly 1 cycle (bus turnaround, no driver enabled), then goes to IDLE; req is not sampled in TURN.
REQ-019 A preempted owner that still holds req competes normally in IDLE; it wins again only if no other requester is pending.
REQ-020 sig_out shall equal sig_in slice i when enable[i]=1; otherwise sig_out shall be all Z.
REQ-021 At most one enable bit shall be high in any cycle, and enable shall always equal grant.
REQ-022 Request bits changing in the same cycle as an arbitration decision shall have no effect; only values sampled at the edge count.
REQ-023 Minimum gap between two ownerships: one TURN cycle plus one IDLE cycle.

Reset
REQ-024 rst high shall immediately, without waiting for a clock edge, force: state=IDLE, grant=0, enable=0, busy=0, hold_cnt=0, last_owner=N_REQ-1; sig_out then goes to all Z.
REQ-025 A reset asserted mid-OWN shall release the bus asynchronously; after reset falls, arbitration restarts from index 0.

Structure
REQ-026 A shared package shall hold the state encoding (IDLE=2'd0, OWN=2'd1, TURN=2'd2) and the default values of N_REQ, WIDTH and MAX_HOLD.
REQ-027 The tri-state driver shall be one sub-module, bus_drv (WIDTH-wide, one enable), instantiated N_REQ times onto sig_out; the FSM, counter and round-robin logic stay in the top module.

Verification
REQ-028 Single requester: req=4'b0100 from IDLE -> grant=4'b0100 one edge later; sig_out=sig_in[2]; req drops -> one cycle with sig_out=Z, then IDLE.
REQ-029 All requesters at once: req=4'b1111 held -> owners in order 0,1,2,3,0; each holds 16 cycles; 2-cycle gap between owners.
REQ-030 Hold limit: MAX_HOLD=4, req=4'b0001 held -> grant high exactly 4 cycles, then TURN, IDLE, and re-grant to 0.
REQ-031 Reset mid-OWN: assert rst between clock edges while grant=4'b1000 -> grant, enable and busy go to 0 before the next edge; first grant after reset goes to the lowest pending index.
REQ-032 Contention check: random req for 10k cycles -> $countones(enable) <= 1 every cycle; sig_out never X; enable==grant every cycle.
